// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, bus widths and the per-pixel control payload
// that travels down the scanout delay pipeline.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Both sync outputs are active low.
  localparam logic SYNC_ACTIVE = 1'b0;

  // Counters are sized for the standard frame; reduced geometries fit as well.
  localparam int unsigned CNT_W  = $clog2((VGA_H_TOTAL > VGA_V_TOTAL) ? VGA_H_TOTAL : VGA_V_TOTAL);
  localparam int unsigned WIN_DIM = 256;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PIX_W  = 3;

  // Decoded attributes of one counter position, delayed alongside the VRAM read.
  typedef struct packed {
    logic vis;
    logic win;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with raw (active-high, undelayed) visible,
// sync and frame-start decodes of the current counter position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic             CLK,
  input  logic             I_RESET_N,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             vis_c,
  output logic             hs_c,
  output logic             vs_c,
  output logic             fs_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  logic h_last;
  logic v_last;

  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  // v advances only on the h wrap
  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign vis_c = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs_c  = (h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END));
  assign vs_c  = (v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END));
  assign fs_c  = (v_cnt == CNT_W'(VS_BEG)) && (h_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// Scans a 256x256 3-bit VRAM window onto a VGA raster: address generation, window
// test, and a control pipeline that keeps colour and sync aligned with the read data.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned      H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned      H_FP     = VGA_H_FP,
  parameter int unsigned      H_SYNC   = VGA_H_SYNC,
  parameter int unsigned      H_BP     = VGA_H_BP,
  parameter int unsigned      V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned      V_FP     = VGA_V_FP,
  parameter int unsigned      V_SYNC   = VGA_V_SYNC,
  parameter int unsigned      V_BP     = VGA_V_BP,
  parameter int unsigned      WIN_X0   = 192,
  parameter int unsigned      WIN_Y0   = 112,
  parameter int unsigned      RD_LAT   = 2,
  parameter logic [PIX_W-1:0] BORDER   = 3'b000
) (
  input  logic              CLK,
  input  logic              I_RESET_N,
  output logic [ADDR_W-1:0] O_VRAM_ADDR,
  input  logic [PIX_W-1:0]  I_VRAM_DATA,
  output logic              O_VGA_R,
  output logic              O_VGA_G,
  output logic              O_VGA_B,
  output logic              O_VGA_HSYNC,
  output logic              O_VGA_VSYNC,
  output logic              O_FRAME_START
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             vis_c;
  logic             hs_c;
  logic             vs_c;
  logic             fs_c;
  logic             win_c;
  logic [7:0]       row_c;
  logic [7:0]       col_c;
  ctl_t             ctl_c;
  ctl_t             ctl_pipe [RD_LAT];
  ctl_t             ctl_tail;
  logic [PIX_W-1:0] rgb_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .CLK       (CLK),
    .I_RESET_N (I_RESET_N),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .vis_c     (vis_c),
    .hs_c      (hs_c),
    .vs_c      (vs_c),
    .fs_c      (fs_c)
  );

  assign win_c = (32'(h_cnt) >= WIN_X0) && (32'(h_cnt) < WIN_X0 + WIN_DIM) &&
                 (32'(v_cnt) >= WIN_Y0) && (32'(v_cnt) < WIN_Y0 + WIN_DIM);
  assign row_c = 8'(v_cnt - CNT_W'(WIN_Y0));
  assign col_c = 8'(h_cnt - CNT_W'(WIN_X0));

  assign ctl_c = '{vis: vis_c, win: win_c, hs: hs_c, vs: vs_c, fs: fs_c};

  // Address only moves inside the window; elsewhere the last fetch is held.
  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_VRAM_ADDR <= '0;
    end else if (win_c) begin
      O_VRAM_ADDR <= {row_c, col_c};
    end
  end

  // Stage 0 loads with the address; the tail lines up with the returning data.
  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        ctl_pipe[i] <= '0;
      end
    end else begin
      ctl_pipe[0] <= ctl_c;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        ctl_pipe[i] <= ctl_pipe[i-1];
      end
    end
  end

  assign ctl_tail = ctl_pipe[RD_LAT-1];

  // The delayed window flag, not a live one, decides whether data is shown.
  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      rgb_q         <= '0;
      O_VGA_HSYNC   <= ~SYNC_ACTIVE;
      O_VGA_VSYNC   <= ~SYNC_ACTIVE;
      O_FRAME_START <= 1'b0;
    end else begin
      O_VGA_HSYNC   <= ctl_tail.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      O_VGA_VSYNC   <= ctl_tail.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      O_FRAME_START <= ctl_tail.fs;
      if (!ctl_tail.vis) begin
        rgb_q <= '0;
      end else if (ctl_tail.win) begin
        rgb_q <= I_VRAM_DATA;
      end else begin
        rgb_q <= BORDER;
      end
    end
  end

  assign O_VGA_R = rgb_q[2];
  assign O_VGA_G = rgb_q[1];
  assign O_VGA_B = rgb_q[0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster: two instances (read latency 2 and 3)
// checked each cycle against an arithmetic raster model, plus fixed pixel points.
module tb_vga_scanout;

  localparam int HA = 40, HF = 4, HS = 8, HB = 8, HT = HA + HF + HS + HB;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int X0 = 10, Y0 = 5;
  localparam int L2 = 3, L3 = 4;
  localparam logic [2:0] BRD = 3'b101;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       fs;
  } out_t;

  logic        CLK = 1'b0;
  logic        I_RESET_N;
  logic [15:0] addr2, addr3;
  logic [2:0]  data2, data3;
  logic        r2, g2, b2, hs2, vs2, fs2;
  logic        r3, g3, b3, hs3, vs3, fs3;

  int          vectors = 0;
  int          miscompares = 0;
  int          kk;
  logic [15:0] exp_addr;

  always #10 CLK = ~CLK;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .WIN_X0(X0), .WIN_Y0(Y0), .RD_LAT(2), .BORDER(BRD)
  ) u_dut2 (
    .CLK(CLK), .I_RESET_N(I_RESET_N), .O_VRAM_ADDR(addr2), .I_VRAM_DATA(data2),
    .O_VGA_R(r2), .O_VGA_G(g2), .O_VGA_B(b2),
    .O_VGA_HSYNC(hs2), .O_VGA_VSYNC(vs2), .O_FRAME_START(fs2)
  );

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .WIN_X0(X0), .WIN_Y0(Y0), .RD_LAT(3), .BORDER(BRD)
  ) u_dut3 (
    .CLK(CLK), .I_RESET_N(I_RESET_N), .O_VRAM_ADDR(addr3), .I_VRAM_DATA(data3),
    .O_VGA_R(r3), .O_VGA_G(g3), .O_VGA_B(b3),
    .O_VGA_HSYNC(hs3), .O_VGA_VSYNC(vs3), .O_FRAME_START(fs3)
  );

  // VRAM: contents = addr[2:0], sampled by the DUT RD_LAT edges after the address launch
  logic [2:0] vram2_q, vram3_q0, vram3_q1;
  always @(posedge CLK) begin
    vram2_q  <= addr2[2:0];
    vram3_q0 <= addr3[2:0];
    vram3_q1 <= vram3_q0;
  end
  assign data2 = vram2_q;
  assign data3 = vram3_q1;

  function automatic bit in_win(input int h, input int v);
    return (h >= X0) && (h < X0 + 256) && (v >= Y0) && (v < Y0 + 256);
  endfunction

  function automatic logic [15:0] win_addr(input int h, input int v);
    return 16'(((v - Y0) % 256) * 256 + ((h - X0) % 256));
  endfunction

  // Outputs seen k edges after reset release, for an instance of total latency lat.
  function automatic out_t model_out(input int k, input int lat);
    out_t o;
    int p, h, v;
    o = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    if (k < lat) return o;
    p = (k - lat) % FRAME;
    h = p % HT;
    v = p / HT;
    o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
    o.fs = (v == VA + VF) && (h == 0);
    if (h < HA && v < VA) o.rgb = in_win(h, v) ? 3'((h - X0) % 8) : BRD;
    return o;
  endfunction

  // k = edges since release; address after edge k+1 reflects counter index k
  always @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      kk       <= 0;
      exp_addr <= '0;
    end else begin
      if (in_win((kk % FRAME) % HT, (kk % FRAME) / HT))
        exp_addr <= win_addr((kk % FRAME) % HT, (kk % FRAME) / HT);
      kk <= kk + 1;
    end
  end

  task automatic check_dut(input string nm, input int lat, input logic [2:0] rgb,
                           input logic hs, input logic vs, input logic fs,
                           input logic [15:0] addr);
    out_t e;
    e = model_out(kk, lat);
    vectors++;
    if ({rgb, hs, vs, fs} !== e || addr !== exp_addr) begin
      miscompares++;
      $display("FAIL %s k=%0d: got rgb=%b hs=%b vs=%b fs=%b addr=%h, want rgb=%b hs=%b vs=%b fs=%b addr=%h",
               nm, kk, rgb, hs, vs, fs, addr, e.rgb, e.hs, e.vs, e.fs, exp_addr);
    end
  endtask

  always @(negedge CLK) begin
    check_dut("cycle_lat2", L2, {r2, g2, b2}, hs2, vs2, fs2, addr2);
    check_dut("cycle_lat3", L3, {r3, g3, b3}, hs3, vs3, fs3, addr3);
  end

  // Sync statistics over the first two full output frames after power-on release
  int   mon_hs_low = 0, mon_vs_low = 0, mon_fs = 0, mon_vs_fall = 0, mon_vs_fall_fs = 0;
  logic mon_done = 1'b0;
  logic vs_prev  = 1'b1;
  always @(negedge CLK) begin
    if (!mon_done && I_RESET_N) begin
      if (kk >= L2 && kk < L2 + 2 * FRAME) begin
        if (!hs2) mon_hs_low++;
        if (!vs2) mon_vs_low++;
        if (fs2) mon_fs++;
        if (vs_prev && !vs2) begin
          mon_vs_fall++;
          if (fs2) mon_vs_fall_fs++;
        end
        vs_prev = vs2;
      end else if (kk >= L2 + 2 * FRAME) begin
        mon_done = 1'b1;
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic wait_k(input int target);
    int n;
    n = 0;
    while (kk < target && n < 4 * FRAME) begin
      @(negedge CLK);
      n++;
    end
    lit($sformatf("wait_k%0d", target), kk, target);
  endtask

  task automatic pin(input int h, input int v, input logic [15:0] want_addr,
                     input logic [2:0] want_rgb, input bit chk_addr);
    int p;
    p = v * HT + h;
    wait_k(p + 1);
    if (chk_addr) begin
      lit($sformatf("addr_lat2(%0d,%0d)", h, v), addr2, want_addr);
      lit($sformatf("addr_lat3(%0d,%0d)", h, v), addr3, want_addr);
    end
    wait_k(p + L2);
    lit($sformatf("rgb_lat2(%0d,%0d)", h, v), {r2, g2, b2}, want_rgb);
    wait_k(p + L3);
    lit($sformatf("rgb_lat3(%0d,%0d)", h, v), {r3, g3, b3}, want_rgb);
  endtask

  task automatic check_reset_vals(input string nm);
    lit({nm, "_rgb2"}, {r2, g2, b2}, 3'b000);
    lit({nm, "_rgb3"}, {r3, g3, b3}, 3'b000);
    lit({nm, "_sync2"}, {hs2, vs2, fs2}, 3'b110);
    lit({nm, "_sync3"}, {hs3, vs3, fs3}, 3'b110);
    lit({nm, "_addr2"}, addr2, 16'h0000);
    lit({nm, "_addr3"}, addr3, 16'h0000);
  endtask

  initial begin
    int target, fall2, fall3, n;

    I_RESET_N = 1'b1;
    #2 I_RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_vals("por");
    #3 I_RESET_N = 1'b1;

    // Fixed raster points of frame 0, in increasing raster order
    pin(0, 0, 16'h0000, BRD, 1'b1);
    pin(39, 0, 16'h0000, BRD, 1'b1);
    pin(45, 3, 16'h0000, 3'b000, 1'b1);
    pin(10, 5, 16'h0000, 3'b000, 1'b1);
    pin(59, 5, 16'h0031, 3'b000, 1'b1);
    pin(18, 6, 16'h0108, 3'b000, 1'b1);
    pin(39, 19, 16'h0E1D, 3'b101, 1'b1);

    wait_k(L2 + 2 * FRAME + 2);
    lit("hsync_low_cycles", mon_hs_low, 2 * VT * HS);
    lit("vsync_low_cycles", mon_vs_low, 2 * VS * HT);
    lit("frame_start_count", mon_fs, 2);
    lit("vsync_wait_completions", mon_vs_fall, 2);
    lit("vsync_fall_with_frame_start", mon_vs_fall_fs, 2);

    // Mid-frame reset at counter position (30,12)
    target = kk + ((12 * HT + 30) - (kk % FRAME) + FRAME) % FRAME;
    if (target <= kk) target += FRAME;
    wait_k(target);
    #2 I_RESET_N = 1'b0;
    #1 check_reset_vals("midframe_rst");
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    #3 I_RESET_N = 1'b1;
    fall2 = -1;
    fall3 = -1;
    n = 0;
    while ((fall2 < 0 || fall3 < 0) && n < 4 * HT) begin
      @(negedge CLK);
      n++;
      if (fall2 < 0 && !hs2) fall2 = kk;
      if (fall3 < 0 && !hs3) fall3 = kk;
    end
    lit("hs_fall_after_rst_lat2", fall2, HA + HF + L2);
    lit("hs_fall_after_rst_lat3", fall3, HA + HF + L3);

    // Randomly timed asynchronous resets of random length
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(50, 2500)) @(negedge CLK);
      #($urandom_range(1, 8)) I_RESET_N = 1'b0;
      repeat ($urandom_range(1, 6)) @(posedge CLK);
      @(negedge CLK);
      #3 I_RESET_N = 1'b1;
    end
    repeat ($urandom_range(200, 400)) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
- REQ-001: Parameter H_ACTIVE, 640, visible pixels per line.
- REQ-002: Parameter H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch and sync widths in clocks (H_TOTAL = 800).
- REQ-003: Parameter V_ACTIVE, 480, visible lines per frame.
- REQ-004: Parameter V_FP/V_SYNC/V_BP, 10/2/33, vertical porch and sync widths in lines (V_TOTAL = 525).
- REQ-005: Parameter WIN_X0/WIN_Y0, 192/112, top-left screen position of the 256x256 VRAM window.
- REQ-006: Parameter RD_LAT, 2, VRAM read latency in clocks, from address to data.
- REQ-007: Parameter BORDER, 3'b000, colour driven for visible pixels outside the window.
- REQ-008: CLK  in  1  pixel clock (25 MHz); one clock domain; all state updates on the rising edge.
- REQ-009: I_RESET_N  in  1  asynchronous, active-low reset.
- REQ-010: O_VRAM_ADDR  out  16  VRAM read address {row[7:0], col[7:0]} (row*256+col).
- REQ-011: I_VRAM_DATA  in  3  VRAM read data, valid RD_LAT clocks after the address.
- REQ-012: O_VGA_R / O_VGA_G / O_VGA_B  out  1 each  pixel colour = data bits [2]/[1]/[0].
- REQ-013: O_VGA_HSYNC / O_VGA_VSYNC  out  1 each  sync outputs, active low.
- REQ-014: O_FRAME_START  out  1  one-clock pulse on the first clock of the VSYNC pulse.

Function
- REQ-015: The horizontal counter h SHALL count 0..H_TOTAL-1 and wrap to 0; v SHALL increment when h wraps, count 0..V_TOTAL-1, and wrap to 0.
- REQ-016: Visible region: h<H_ACTIVE and v<V_ACTIVE; hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync active for the analogous v range.
- REQ-017: Window: WIN_X0<=h<WIN_X0+256 and WIN_Y0<=v<WIN_Y0+256; inside it col=h-WIN_X0 and row=v-WIN_Y0, both truncated to 8 bits.
- REQ-018: O_VRAM_ADDR SHALL be registered one clock after the counters; outside the window it SHALL hold its last value.
- REQ-019: Total latency L = 1+RD_LAT clocks: RGB, HSYNC, VSYNC and FRAME_START for counter position (h,v) SHALL all appear L clocks after the counters equal (h,v).
- REQ-020: Colour SHALL be I_VRAM_DATA inside the window, BORDER in the visible region outside the window, and 0 during blanking.
- REQ-021: A window edge that coincides with a line wrap (h=799 to 0) SHALL NOT leak pixel data into blanking; the window flag SHALL be piped alongside the data.
- REQ-022: O_VGA_VSYNC SHALL be stable across each line: its transitions occur only at the delayed h=0.

Reset
- REQ-023: While I_RESET_N=0: h=v=0, O_VRAM_ADDR=0, RGB=0, HSYNC=VSYNC=1, FRAME_START=0, and all pipeline stages cleared.
- REQ-024: Reset asserted mid-frame SHALL take effect immediately (asynchronously); after release, the frame restarts at (0,0) with no partial sync pulse emitted.
- REQ-025: The first valid pixel SHALL appear L clocks after the first clock edge following release.

Structure
- REQ-026: Timing constants, H_TOTAL/V_TOTAL, and the sync-polarity constant SHALL live in the shared package vga_timing_pkg.
- REQ-027: The counters and raw sync/visible decoding SHALL be the sub-module vga_timing_gen; vga_scanout SHALL add the address generation, the window test and the delay pipeline.
- REQ-028: The delay pipeline SHALL be parameterised by RD_LAT, with no hard-coded stage count.

Verification
- REQ-029: Reset release, then run 2 frames -> HSYNC low for 96 clocks every 800 clocks; VSYNC low for 2 lines every 525 lines; one FRAME_START per frame.
- REQ-030: VRAM model with data = addr[2:0] and latency 2; sample pixel (h=192,v=112) -> O_VRAM_ADDR=0x0000 and RGB=000; at (h=200,v=113) -> addr 0x0108, RGB=000; at (h=447,v=367) -> addr 0xFFFF, RGB=111.
- REQ-031: BORDER=3'b101; check pixels (0,0) and (639,479) -> RGB=101; check h=640..799 -> RGB=000.
- REQ-032: Assert reset at (h=300,v=200) for 5 clocks -> outputs at reset values immediately; after release, the next HSYNC fall occurs exactly 656+L clocks later.
- REQ-033: RD_LAT=3 rebuild; rerun REQ-030 -> same pixel values with sync/RGB alignment preserved, L=4.
- REQ-034: Drive the core's vsync-wait handshake from O_VGA_VSYNC -> the wait completes once per frame, on VSYNC falling.
